// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, register IDs and the writeback FSM state type.
package y86_pkg;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RSP      = 4'h4;

  typedef enum logic [1:0] {IDLE, WR_E, WR_M} wb_state_t;
endpackage

// File: rtl/wb_hazard_match.sv
// One decode read port: flags a match against pending E/M destinations and forwards the value.
module wb_hazard_match #(
  parameter int N = 64,
  parameter int RID_W = 4,
  parameter logic [RID_W-1:0] RNONE = 4'hF
) (
  input  logic [RID_W-1:0] rd_addr,
  input  logic [RID_W-1:0] dst_e,
  input  logic [RID_W-1:0] dst_m,
  input  logic [N-1:0]     val_e,
  input  logic [N-1:0]     val_m,
  input  logic             vld_e,
  input  logic             vld_m,
  output logic             haz,
  output logic [N-1:0]     fwd
);
  logic hit_e, hit_m;

  assign hit_e = vld_e && (rd_addr != RNONE) && (rd_addr == dst_e);
  assign hit_m = vld_m && (rd_addr != RNONE) && (rd_addr == dst_m);
  assign haz   = hit_e | hit_m;
  // M is written last, so it is the value a later reader must see.
  assign fwd   = hit_m ? val_m : (hit_e ? val_e : '0);
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Serializes up to two writebacks per retiring instruction onto one register-file port (E then M).
module regfile_wb_scheduler #(
  parameter int N = 64,
  parameter int RID_W = 4,
  parameter logic [RID_W-1:0] RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_icode,
  input  logic             in_cnd,
  input  logic [RID_W-1:0] in_dstE,
  input  logic [RID_W-1:0] in_dstM,
  input  logic [N-1:0]     in_valE,
  input  logic [N-1:0]     in_valM,
  output logic             wr_en,
  output logic [RID_W-1:0] wr_addr,
  output logic [N-1:0]     wr_data,
  input  logic [RID_W-1:0] rd_addrA,
  input  logic [RID_W-1:0] rd_addrB,
  output logic             hazA,
  output logic             hazB,
  output logic [N-1:0]     fwdA,
  output logic [N-1:0]     fwdB,
  output logic [31:0]      retired
);
  import y86_pkg::*;

  wb_state_t        state_q, state_d;
  logic [RID_W-1:0] dst_e_q, dst_m_q, eff_dst_e;
  logic [N-1:0]     val_e_q, val_m_q;
  logic [31:0]      retired_q;
  logic             accept, retire;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid & in_ready;
  // A cmov whose condition failed has no E destination.
  assign eff_dst_e = (in_icode == I_RRMOVQ && !in_cnd) ? RNONE : in_dstE;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (eff_dst_e != RNONE)    state_d = WR_E;
        else if (in_dstM != RNONE) state_d = WR_M;
        else                       retire  = 1'b1;
      end
      WR_E: if (dst_m_q != RNONE) state_d = WR_M;
            else begin state_d = IDLE; retire = 1'b1; end
      WR_M: begin state_d = IDLE; retire = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dst_e_q   <= RNONE;
      dst_m_q   <= RNONE;
      val_e_q   <= '0;
      val_m_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dst_e_q <= eff_dst_e;
        dst_m_q <= in_dstM;
        val_e_q <= in_valE;
        val_m_q <= in_valM;
      end
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
  assign wr_en   = (state_q == WR_E) || (state_q == WR_M);
  assign wr_addr = (state_q == WR_E) ? dst_e_q : ((state_q == WR_M) ? dst_m_q : RNONE);
  assign wr_data = (state_q == WR_E) ? val_e_q : ((state_q == WR_M) ? val_m_q : '0);

  // E stays pending through WR_E; M stays pending through WR_E and WR_M.
  logic                  vld_e, vld_m;
  logic [1:0][RID_W-1:0] rd_addr;
  logic [1:0]            haz;
  logic [1:0][N-1:0]     fwd;

  assign vld_e   = (state_q == WR_E);
  assign vld_m   = (state_q == WR_E) || (state_q == WR_M);
  assign rd_addr = {rd_addrB, rd_addrA};

  for (genvar p = 0; p < 2; p++) begin : g_port
    wb_hazard_match #(.N(N), .RID_W(RID_W), .RNONE(RNONE)) u_match (
      .rd_addr (rd_addr[p]),
      .dst_e   (dst_e_q),
      .dst_m   (dst_m_q),
      .val_e   (val_e_q),
      .val_m   (val_m_q),
      .vld_e   (vld_e),
      .vld_m   (vld_m),
      .haz     (haz[p]),
      .fwd     (fwd[p])
    );
  end

  assign hazA = haz[0];
  assign hazB = haz[1];
  assign fwdA = fwd[0];
  assign fwdB = fwd[1];
endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Sequences register-file writeback for the sequential Y86-64 core through a single register-file write port. Each retiring instruction delivers up to two results (`valE` to `dstE`, `valM` to `dstM`), so `popq` needs two writes. The block accepts one writeback request per handshake and serializes the writes with an E-then-M state machine. It also reports pending-write hazards and forwards values to the decode read ports.

## Interface
- `N`, 64, data width of `valE`/`valM`/register contents
- `RID_W`, 4, register-ID width
- `RNONE`, 4'hF, register ID meaning "no destination"; never written
- `clk` input 1: single clock, rising-edge
- `rst_n` input 1: asynchronous, active-low reset
- `in_valid` input 1: writeback request valid
- `in_ready` output 1: scheduler can accept a request
- `in_icode` input 4: icode of the retiring instruction
- `in_cnd` input 1: condition result; used only for icode 2
- `in_dstE` input RID_W: E destination
- `in_dstM` input RID_W: M destination
- `in_valE` input N: E result
- `in_valM` input N: M result
- `wr_en` output 1: register-file write strobe
- `wr_addr` output RID_W: write register
- `wr_data` output N: write data
- `rd_addrA`, `rd_addrB` input RID_W: decode read addresses
- `hazA`, `hazB` output 1: the read address matches a not-yet-written destination
- `fwdA`, `fwdB` output N: pending value for the matched address
- `retired` output 32: count of completed writeback requests

## Operation
- States: `IDLE`, `WR_E`, `WR_M`. `in_ready` = (state == `IDLE`).
- Accept occurs on a rising edge where `in_valid & in_ready`. On accept:
  - Latch `dstE`, `dstM`, `valE`, `valM`.
  - If `in_icode == 2` and `!in_cnd`, latch `dstE` as `RNONE` (cmov not taken).
- Next state after accept:
  - `WR_E` if the effective `dstE != RNONE`.
  - Otherwise `WR_M` if `dstM != RNONE`.
  - Otherwise stay in `IDLE` and increment `retired` (no-write instruction).
- In `WR_E`: `wr_en = 1`, `wr_addr = dstE`, `wr_data = valE`. Next state is `WR_M` if `dstM != RNONE`; otherwise `IDLE` with `retired` incremented.
- In `WR_M`: `wr_en = 1`, `wr_addr = dstM`, `wr_data = valM`. Next state is `IDLE`; `retired` increments.
- `dstE == dstM` (e.g. `popq %rsp`): both writes are issued, and M is written last, so M wins.
- `wr_en`, `wr_addr` and `wr_data` decode from state and latched registers only; they never depend combinationally on `in_*`.
- Hazard and forwarding: a destination is pending from accept until the edge that ends its write state.
  - `hazA = 1` if `rd_addrA != RNONE` and it matches a pending dstE or dstM.
  - `fwdA` gives the pending M value when dstM matches, else the E value, else 0.
  - `hazB`/`fwdB` follow the same rules.
- `retired` wraps modulo 2^32.

## Timing
- Request accepted at edge T:
  - E write strobes during cycle T..T+1 and commits at edge T+1.
  - M write strobes during the following cycle.
- Throughput:
  - Two-write request: 3 cycles per request (accept, E, M).
  - One-write request: 2 cycles per request.
  - No-write request: 1 cycle per request.
- Hazard and forward outputs are combinational from state, latched registers and `rd_addr*`. They are valid in the same cycle.
- Reset (asynchronous assert, synchronous-safe release):
  - state = `IDLE`, `in_ready = 1`, `wr_en = 0`.
  - `wr_addr = RNONE`, `wr_data = 0`.
  - Latched destinations = `RNONE`, latched values = 0.
  - `hazA`/`hazB` = 0, `fwdA`/`fwdB` = 0, `retired = 0`.
- Reset mid-operation (in `WR_E` or `WR_M`): the remaining write is dropped and `retired` does not count that request. Later requests are accepted normally.
- `in_valid` while not ready: the request must be held by the producer; nothing is sampled.

## Structure
- Shared package `y86_pkg`: icode constants (`I_RRMOVQ=2`, `I_IRMOVQ=3`, `I_MRMOVQ=5`, `I_OPQ=6`, `I_CALL=8`, `I_RET=9`, `I_PUSHQ=10`, `I_POPQ=11`), `RNONE`, `RSP=4`, and the state enum.
- One sub-module, `wb_hazard_match`, instantiated twice (ports A and B). It takes the read address, pending destinations/values and valid flags, and produces the hazard flag and forwarded value.

## Test plan
- irmovq: dstE=3, valE=0x55, dstM=F, accepted at edge 1 → edge 2 writes r3=0x55 with a single `wr_en` pulse; `retired = 1`; `in_ready` high again after edge 2.
- popq %rbx: dstE=4 valE=0x18, dstM=3 valM=0xAB → cycle 1 writes r4=0x18, cycle 2 writes r3=0xAB; `in_ready` low for 2 cycles.
- popq %rsp: dstE=dstM=4, valE=0x18, valM=0x99 → r4 written 0x18, then 0x99; `fwdA` with `rd_addrA=4` during `WR_E` shows 0x99.
- cmov not taken: icode 2, cnd=0, dstE=5 → no `wr_en`; `retired` increments at the accept edge; `hazA` with `rd_addrA=5` stays 0.
- Hazard: pushq-style request dstE=4 valE=0x08, `rd_addrB=4` → `hazB = 1`, `fwdB = 0x08` until the E write commits, then `hazB = 0`.
- Reset mid-op: `rst_n` low in `WR_E` of a popq → `wr_en` drops immediately and no M write follows; after release `in_ready = 1`, `retired` is unchanged, and the next irmovq completes normally.
